// File: rtl/tiny_computer.sv
// tiny_computer: 8-bit accumulator processor with a 128-byte EPROM (0x00-0x7F)
// and a 128-byte RAM (0x80-0xFF) sharing one address/data bus.

module tiny_computer_prom #(
    parameter PROM_INIT = ""
) (
    input  logic [6:0] addr,
    output logic [7:0] rdata
);
    logic [7:0] LOCATION [0:127];

    assign rdata = LOCATION[addr];
endmodule

module tiny_computer_ram (
    input  logic       clock,
    input  logic       we,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] LOCATION [0:127];

    assign rdata = LOCATION[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            LOCATION[addr] <= wdata;
        end
    end
endmodule

module tiny_computer_mem #(
    parameter PROM_INIT = ""
) (
    input  logic       clock,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic [7:0] rdata
);
    logic [7:0] prm_rdata;
    logic [7:0] rm_rdata;

    tiny_computer_prom #(.PROM_INIT(PROM_INIT)) prm (
        .addr  (addr[6:0]),
        .rdata (prm_rdata)
    );

    // Writes into the EPROM half are simply dropped here.
    tiny_computer_ram rm (
        .clock (clock),
        .we    (we & addr[7]),
        .addr  (addr[6:0]),
        .wdata (wdata),
        .rdata (rm_rdata)
    );

    assign rdata = addr[7] ? rm_rdata : prm_rdata;
endmodule

module tiny_computer_proc (
    input  logic       clock,
    input  logic       rst,
    input  logic [7:0] rdata,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    output logic       we,
    output logic       halted,
    output logic [7:0] acc,
    output logic [7:0] ip
);
    typedef enum logic [7:0] {
        FETCH_OP  = 8'd0,
        FETCH_ARG = 8'd1,
        EXEC      = 8'd2,
        HALT      = 8'd42
    } state_e;

    localparam logic [7:0] OP_HLT = 8'h00;
    localparam logic [7:0] OP_LDI = 8'h01;
    localparam logic [7:0] OP_LDA = 8'h02;
    localparam logic [7:0] OP_STA = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h04;
    localparam logic [7:0] OP_SUB = 8'h05;
    localparam logic [7:0] OP_JMP = 8'h06;
    localparam logic [7:0] OP_JZ  = 8'h07;
    localparam logic [7:0] OP_NOP = 8'h08;

    state_e     STAR, star_d;
    logic [7:0] ip_q, ip_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] opnd_q, opnd_d;
    logic       z_q, z_d;
    logic       we_c;

    function automatic logic has_operand(input logic [7:0] op);
        return (op >= OP_LDI) && (op <= OP_JZ);
    endfunction

    always_comb begin
        star_d   = STAR;
        ip_d     = ip_q;
        acc_d    = acc_q;
        opcode_d = opcode_q;
        opnd_d   = opnd_q;
        z_d      = z_q;
        addr     = ip_q;
        wdata    = acc_q;
        we_c     = 1'b0;
        case (STAR)
            FETCH_OP: begin
                opcode_d = rdata;
                ip_d     = ip_q + 8'd1;
                star_d   = FETCH_ARG;
            end
            FETCH_ARG: begin
                if (has_operand(opcode_q)) begin
                    opnd_d = rdata;
                    ip_d   = ip_q + 8'd1;
                end
                star_d = EXEC;
            end
            EXEC: begin
                // The operand doubles as the data address during execution.
                addr   = opnd_q;
                star_d = FETCH_OP;
                case (opcode_q)
                    OP_LDI: begin
                        acc_d = opnd_q;
                        z_d   = (opnd_q == 8'd0);
                    end
                    OP_LDA: begin
                        acc_d = rdata;
                        z_d   = (rdata == 8'd0);
                    end
                    OP_STA: we_c = 1'b1;
                    OP_ADD: begin
                        acc_d = acc_q + rdata;
                        z_d   = ((acc_q + rdata) == 8'd0);
                    end
                    OP_SUB: begin
                        acc_d = acc_q - rdata;
                        z_d   = ((acc_q - rdata) == 8'd0);
                    end
                    OP_JMP: ip_d = opnd_q;
                    OP_JZ: begin
                        if (z_q) begin
                            ip_d = opnd_q;
                        end
                    end
                    OP_NOP: ;
                    default: star_d = HALT;
                endcase
            end
            HALT: ;
            default: star_d = HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            STAR     <= FETCH_OP;
            ip_q     <= 8'h00;
            acc_q    <= 8'h00;
            opcode_q <= 8'h00;
            opnd_q   <= 8'h00;
            z_q      <= 1'b0;
        end else begin
            STAR     <= star_d;
            ip_q     <= ip_d;
            acc_q    <= acc_d;
            opcode_q <= opcode_d;
            opnd_q   <= opnd_d;
            z_q      <= z_d;
        end
    end

    // A reset landing on a store's execute cycle must not let the write through.
    assign we     = we_c & ~rst;
    assign halted = (STAR == HALT);
    assign acc    = acc_q;
    assign ip     = ip_q;

    logic unused_op;
    assign unused_op = (opcode_q == OP_HLT);
endmodule

module tiny_computer #(
    parameter PROM_INIT = ""
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       on_switch,
    input  logic       reset_switch,
    output logic       halted,
    output logic [7:0] acc,
    output logic [7:0] ip
);
    logic       rst;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_we;

    assign rst = !reset_ | reset_switch | !on_switch;

    tiny_computer_proc proc (
        .clock  (clock),
        .rst    (rst),
        .rdata  (bus_rdata),
        .addr   (bus_addr),
        .wdata  (bus_wdata),
        .we     (bus_we),
        .halted (halted),
        .acc    (acc),
        .ip     (ip)
    );

    tiny_computer_mem #(.PROM_INIT(PROM_INIT)) mem (
        .clock (clock),
        .addr  (bus_addr),
        .wdata (bus_wdata),
        .we    (bus_we),
        .rdata (bus_rdata)
    );
endmodule

// File: tb/tb_tiny_computer.sv
// Directed-program bench for tiny_computer: preload EPROM/RAM, run to halt, inspect state and RAM.

module tb_tiny_computer;
    logic       clock = 1'b0;
    logic       reset_ = 1'b1;
    logic       on_switch = 1'b0;
    logic       reset_switch = 1'b0;
    logic       halted;
    logic [7:0] acc;
    logic [7:0] ip;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc;
    logic [7:0] prog [$];

    tiny_computer dut (
        .clock        (clock),
        .reset_       (reset_),
        .on_switch    (on_switch),
        .reset_switch (reset_switch),
        .halted       (halted),
        .acc          (acc),
        .ip           (ip)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        tick(1);
        reset_ = 1'b1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 128; i++) dut.mem.prm.LOCATION[i] = 8'h00;
        for (int i = 0; i < prog.size(); i++) dut.mem.prm.LOCATION[i] = prog[i];
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 128; i++) dut.mem.rm.LOCATION[i] = 8'h00;
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        cycles = 0;
        while (!halted && cycles < budget) begin
            tick(1);
            cycles++;
        end
    endtask

    initial begin
        // Power-up: switch off for 3 cycles, then on. LDI 5; STA 0x80; HLT
        prog = '{8'h01, 8'h05, 8'h03, 8'h80, 8'h00};
        load_prog();
        clear_ram();
        tick(3);
        check_eq("pwr_star", dut.proc.STAR, 32'd0);
        check_eq("pwr_ip", ip, 32'h00);
        check_eq("pwr_acc", acc, 32'h00);
        check_eq("pwr_halted", halted, 32'd0);
        on_switch = 1'b1;
        run_to_halt(100, cyc);
        check_eq("pwr_cycles", cyc, 32'd9);
        check_eq("pwr_star42", dut.proc.STAR, 32'd42);
        check_eq("pwr_ram80", dut.mem.rm.LOCATION[0], 32'h05);
        check_eq("pwr_acc_end", acc, 32'h05);
        tick(4);
        check_eq("pwr_stay_halted", halted, 32'd1);
        check_eq("pwr_ip_end", ip, 32'h05);

        // Add with wraparound: 0xF0 + 0x20 = 0x10
        prog = '{8'h01, 8'hF0, 8'h03, 8'h81, 8'h01, 8'h20, 8'h04, 8'h81, 8'h03, 8'h82, 8'h00};
        load_prog();
        clear_ram();
        do_reset();
        run_to_halt(200, cyc);
        check_eq("add_cycles", cyc, 32'd18);
        check_eq("add_ram81", dut.mem.rm.LOCATION[1], 32'hF0);
        check_eq("add_ram82", dut.mem.rm.LOCATION[2], 32'h10);
        check_eq("add_acc", acc, 32'h10);
        check_eq("add_z", dut.proc.z_q, 32'd0);

        // Countdown loop 3->0 with RAM[0x90]=1 preset
        prog = '{8'h01, 8'h03, 8'h03, 8'h80, 8'h02, 8'h80, 8'h05, 8'h90,
                 8'h03, 8'h80, 8'h07, 8'h0E, 8'h06, 8'h04, 8'h00};
        load_prog();
        clear_ram();
        dut.mem.rm.LOCATION[16] = 8'h01;
        do_reset();
        run_to_halt(400, cyc);
        check_eq("br_cycles", cyc, 32'd51);
        check_eq("br_ram80", dut.mem.rm.LOCATION[0], 32'h00);
        check_eq("br_acc", acc, 32'h00);
        check_eq("br_z", dut.proc.z_q, 32'd1);
        check_eq("br_ip", ip, 32'h0F);

        // EPROM protection: STA 0x10 leaves the ROM byte alone and execution continues
        prog = '{8'h01, 8'h55, 8'h03, 8'h10, 8'h01, 8'h07, 8'h03, 8'h83, 8'h00};
        load_prog();
        dut.mem.prm.LOCATION[16] = 8'hA5;
        clear_ram();
        do_reset();
        run_to_halt(200, cyc);
        check_eq("rom_cycles", cyc, 32'd15);
        check_eq("rom_byte10", dut.mem.prm.LOCATION[16], 32'hA5);
        check_eq("rom_ram83", dut.mem.rm.LOCATION[3], 32'h07);
        check_eq("rom_acc", acc, 32'h07);

        // Illegal opcode at address 0
        prog = '{8'hFF};
        load_prog();
        do_reset();
        run_to_halt(50, cyc);
        check_eq("ill_cycles", cyc, 32'd3);
        check_eq("ill_star", dut.proc.STAR, 32'd42);
        tick(5);
        check_eq("ill_stay_halted", halted, 32'd1);
        check_eq("ill_ip", ip, 32'h01);

        // Reset_switch pulse mid-program; RAM survives, program reruns
        prog = '{8'h01, 8'hF0, 8'h03, 8'h81, 8'h01, 8'h20, 8'h04, 8'h81, 8'h03, 8'h82, 8'h00};
        load_prog();
        clear_ram();
        do_reset();
        tick(10);
        check_eq("rsw_acc_mid", acc, 32'h20);
        reset_switch = 1'b1;
        tick(1);
        reset_switch = 1'b0;
        check_eq("rsw_star", dut.proc.STAR, 32'd0);
        check_eq("rsw_ip", ip, 32'h00);
        check_eq("rsw_acc", acc, 32'h00);
        check_eq("rsw_ram81_kept", dut.mem.rm.LOCATION[1], 32'hF0);
        run_to_halt(200, cyc);
        check_eq("rsw_cycles", cyc, 32'd18);
        check_eq("rsw_ram82", dut.mem.rm.LOCATION[2], 32'h10);

        // Reset on the STA execute cycle suppresses the write
        prog = '{8'h01, 8'h05, 8'h03, 8'h80, 8'h00};
        load_prog();
        clear_ram();
        dut.mem.rm.LOCATION[0] = 8'h33;
        do_reset();
        tick(5);
        check_eq("sup_star_exec", dut.proc.STAR, 32'd2);
        reset_switch = 1'b1;
        tick(1);
        reset_switch = 1'b0;
        check_eq("sup_ram80", dut.mem.rm.LOCATION[0], 32'h33);
        check_eq("sup_star", dut.proc.STAR, 32'd0);
        run_to_halt(100, cyc);
        check_eq("sup_cycles", cyc, 32'd9);
        check_eq("sup_ram80_end", dut.mem.rm.LOCATION[0], 32'h05);

        // Power switch off mid-run restarts from IP 0
        do_reset();
        tick(4);
        on_switch = 1'b0;
        tick(2);
        check_eq("off_ip", ip, 32'h00);
        on_switch = 1'b1;
        run_to_halt(100, cyc);
        check_eq("off_cycles", cyc, 32'd9);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
